// File: rtl/lif_post_neuron.sv
// Leaky integrate-and-fire postsynaptic neuron with shift leak and refractory period.
// Optional macro ADAPTIVE_THRESH_EN adds a spike-driven threshold offset.
module lif_post_neuron #(
  parameter int unsigned MEM_W         = 8,
  parameter int unsigned LEAK_SHIFT    = 3,
  parameter int unsigned REFRAC_CYCLES = 4,
  parameter int unsigned THRESH_STEP   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       pre_spike,
  input  logic [15:0]      weight,
  input  logic [MEM_W-1:0] threshold,
  output logic             post_spike,
  output logic [MEM_W-1:0] membrane,
  output logic             refractory,
  output logic [7:0]       spike_count
);

  localparam int unsigned CntW = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;
  localparam logic [MEM_W-1:0] VMax    = '1;
  localparam logic [CntW-1:0]  CntLoad = CntW'(REFRAC_CYCLES);

  typedef enum logic [0:0] {StIntegrate, StRefractory} state_e;

  state_e           state_q, state_d;
  logic [MEM_W-1:0] v_q, v_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             post_q, post_d;
  logic [7:0]       count_q, count_d;

  logic [5:0]       in_sum;
  logic [MEM_W-1:0] leak;
  logic [MEM_W:0]   v_sum;
  logic [MEM_W-1:0] v_next;
  logic [MEM_W-1:0] thr_base;
  logic [MEM_W-1:0] thr_eff;
  logic             fire;

  // pre0 owns the top nibble, pre3 the bottom one
  always_comb begin
    in_sum = '0;
    for (int i = 0; i < 4; i++) begin
      if (pre_spike[i]) begin
        in_sum = in_sum + 6'(weight[15-4*i -: 4]);
      end
    end
  end

  always_comb begin
    leak   = v_q >> LEAK_SHIFT;
    v_sum  = {1'b0, v_q - leak} + (MEM_W + 1)'(in_sum);
    v_next = v_sum[MEM_W] ? VMax : v_sum[MEM_W-1:0];
  end

  assign thr_base = (threshold == '0) ? MEM_W'(1) : threshold;

`ifdef ADAPTIVE_THRESH_EN
  localparam int unsigned ThrSumW = ((MEM_W > 8) ? MEM_W : 8) + 1;
  localparam logic [8:0]  StepSat = (THRESH_STEP > 255) ? 9'd255 : 9'(THRESH_STEP);

  logic [7:0]         off_q, off_d;
  logic [ThrSumW-1:0] thr_sum;
  logic [8:0]         off_inc;

  always_comb begin
    thr_sum = ThrSumW'(thr_base) + ThrSumW'(off_q);
    thr_eff = (thr_sum > ThrSumW'(VMax)) ? VMax : thr_sum[MEM_W-1:0];
  end

  // Offset moves only on enabled INTEGRATE edges; refractory holds it
  always_comb begin
    off_inc = {1'b0, off_q} + StepSat;
    off_d   = off_q;
    if (en && (state_q == StIntegrate)) begin
      if (fire) begin
        off_d = off_inc[8] ? 8'hff : off_inc[7:0];
      end else if (off_q != '0) begin
        off_d = off_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q <= '0;
    end else begin
      off_q <= off_d;
    end
  end
`else
  logic unused_thresh_step;
  assign unused_thresh_step = ^THRESH_STEP;
  assign thr_eff = thr_base;
`endif

  assign fire = (v_next >= thr_eff);

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    post_d  = 1'b0;
    if (en) begin
      unique case (state_q)
        StIntegrate: begin
          if (fire) begin
            v_d     = '0;
            post_d  = 1'b1;
            count_d = count_q + 8'd1;
            if (REFRAC_CYCLES != 0) begin
              state_d = StRefractory;
              cnt_d   = CntLoad;
            end
          end else begin
            v_d = v_next;
          end
        end
        StRefractory: begin
          v_d = '0;
          if (cnt_q == CntW'(1)) begin
            state_d = StIntegrate;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        default: state_d = StIntegrate;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIntegrate;
      v_q     <= '0;
      cnt_q   <= '0;
      post_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      post_q  <= post_d;
      count_q <= count_d;
    end
  end

  assign post_spike  = post_q;
  assign membrane    = v_q;
  assign refractory  = (state_q == StRefractory);
  assign spike_count = count_q;

endmodule

// File: tb/tb_lif_post_neuron.sv
// Randomized and directed bench for lif_post_neuron against an arithmetic reference model.
module tb_lif_post_neuron;

  localparam int MemW    = 8;
  localparam int LeakSh  = 3;
  localparam int Refrac  = 4;
  localparam int ThrStep = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic [3:0]      pre_spike = '0;
  logic [15:0]     weight = '0;
  logic [MemW-1:0] threshold = '0;
  logic            post_spike;
  logic [MemW-1:0] membrane;
  logic            refractory;
  logic [7:0]      spike_count;

  lif_post_neuron dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pre_spike  (pre_spike),
    .weight     (weight),
    .threshold  (threshold),
    .post_spike (post_spike),
    .membrane   (membrane),
    .refractory (refractory),
    .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_v, m_refrac, m_post, m_cnt, m_off;
  int edge_no;
  int spk_edges[$];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int wsum(input logic [3:0] p, input logic [15:0] w);
    int s = 0;
    for (int i = 0; i < 4; i++) begin
      if (p[i]) s += int'(w[15-4*i -: 4]);
    end
    return s;
  endfunction

  task automatic model_reset();
    m_v = 0; m_refrac = 0; m_post = 0; m_cnt = 0; m_off = 0;
  endtask

  task automatic model_step(input logic e, input logic [3:0] p, input logic [15:0] w,
                            input logic [MemW-1:0] t);
    int vn, thr, vmax;
    vmax = (1 << MemW) - 1;
    m_post = 0;
    if (!e) return;
    if (m_refrac > 0) begin
      m_refrac--;
      return;
    end
    vn = m_v - (m_v >> LeakSh) + wsum(p, w);
    if (vn > vmax) vn = vmax;
    thr = (t == 0) ? 1 : int'(t);
`ifdef ADAPTIVE_THRESH_EN
    thr += m_off;
    if (thr > vmax) thr = vmax;
`endif
    if (vn >= thr) begin
      m_v = 0;
      m_post = 1;
      m_cnt = (m_cnt + 1) % 256;
      m_refrac = Refrac;
      m_off = (m_off + ThrStep > 255) ? 255 : m_off + ThrStep;
    end else begin
      m_v = vn;
      if (m_off > 0) m_off--;
    end
  endtask

  task automatic cycle(input logic e, input logic [3:0] p, input logic [15:0] w,
                       input logic [MemW-1:0] t);
    en = e; pre_spike = p; weight = w; threshold = t;
    @(posedge clk);
    model_step(e, p, w, t);
    edge_no++;
    #1;
    check_eq("post_spike", int'(post_spike), m_post);
    check_eq("membrane", int'(membrane), m_v);
    check_eq("refractory", int'(refractory), (m_refrac > 0) ? 1 : 0);
    check_eq("spike_count", int'(spike_count), m_cnt);
    if (post_spike) spk_edges.push_back(edge_no);
  endtask

  // Called at posedge+1; checks the asynchronous clear before the next edge
  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    check_eq("rst_post", int'(post_spike), 0);
    check_eq("rst_membrane", int'(membrane), 0);
    check_eq("rst_refractory", int'(refractory), 0);
    check_eq("rst_count", int'(spike_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    edge_no = 0;
    spk_edges.delete();
  endtask

  initial begin
    int bound;
    model_reset();
    edge_no = 0;
    @(posedge clk);
    #1;
    apply_reset();

    // Scenario 1: steady single input
    for (int k = 0; k < 12; k++) begin
      cycle(1'b1, 4'b0001, 16'hF000, 8'd40);
      if (k == 0) check_eq("s1_v_edge1", int'(membrane), 15);
      if (k == 1) check_eq("s1_v_edge2", int'(membrane), 29);
    end
    check_eq("s1_nspikes", spk_edges.size(), 2);
    if (spk_edges.size() >= 2) begin
      check_eq("s1_first_spike", spk_edges[0], 3);
`ifdef ADAPTIVE_THRESH_EN
      check_eq("s1_second_spike", spk_edges[1], 11);
`else
      check_eq("s1_second_spike", spk_edges[1], 10);
`endif
    end

    // Scenario 2: single pulse decays to the leak floor
    apply_reset();
    cycle(1'b1, 4'b0010, 16'h0F00, 8'd255);
    check_eq("s2_v_edge1", int'(membrane), 15);
    for (int k = 0; k < 14; k++) cycle(1'b1, 4'b0000, 16'h0F00, 8'd255);
    check_eq("s2_floor", int'(membrane), 7);
    check_eq("s2_nspikes", spk_edges.size(), 0);

    // Scenario 3: saturation then fire
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 4'b1111, 16'hFFFF, 8'd255);
      if (k == 4) check_eq("s3_v_edge5", int'(membrane), 235);
    end
    check_eq("s3_nspikes", spk_edges.size(), 1);
    if (spk_edges.size() >= 1) check_eq("s3_spike_edge", spk_edges[0], 6);

    // Scenario 4: reset asserted mid-refractory
    apply_reset();
    for (int k = 0; k < 5; k++) cycle(1'b1, 4'b0001, 16'hF000, 8'd40);
    check_eq("s4_pre_reset_refrac", int'(refractory), 1);
    apply_reset();
    for (int k = 0; k < 3; k++) cycle(1'b1, 4'b0001, 16'hF000, 8'd40);
    check_eq("s4_nspikes", spk_edges.size(), 1);
    if (spk_edges.size() >= 1) check_eq("s4_spike_edge", spk_edges[0], 3);

    // Scenario 5: enable dropped for 5 cycles during refractory
    apply_reset();
    for (int k = 0; k < 17; k++) begin
      cycle((k >= 4 && k <= 8) ? 1'b0 : 1'b1, 4'b0001, 16'hF000, 8'd40);
      if (k == 8) check_eq("s5_frozen_refrac", int'(refractory), 1);
    end
    check_eq("s5_nspikes", spk_edges.size(), 2);
    if (spk_edges.size() >= 2) begin
`ifdef ADAPTIVE_THRESH_EN
      check_eq("s5_second_spike", spk_edges[1], 16);
`else
      check_eq("s5_second_spike", spk_edges[1], 15);
`endif
    end

    // Scenario 6: zero threshold behaves as one
    apply_reset();
    for (int k = 0; k < 4; k++) cycle(1'b1, 4'b0000, 16'hFFFF, 8'd0);
    check_eq("s6_thr0_nospike", spk_edges.size(), 0);

    // Scenario 7: spike counter wraps after 256 spikes
    apply_reset();
    bound = 0;
    while (spk_edges.size() < 256 && bound < 20000) begin
      cycle(1'b1, 4'b1111, 16'hFFFF, 8'd1);
      bound++;
    end
    check_eq("s7_reached_256", spk_edges.size(), 256);
    check_eq("s7_count_wrap", int'(spike_count), 0);

    // Randomized phase
    apply_reset();
    for (int k = 0; k < 1500; k++) begin
      logic [MemW-1:0] t;
      t = ($urandom_range(0, 15) == 0) ? '0 : MemW'($urandom_range(1, 120));
      if ($urandom_range(0, 99) == 0) begin
        apply_reset();
      end else begin
        cycle(($urandom_range(0, 9) != 0), 4'($urandom), 16'($urandom), t);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
